ysyx_24100005_regfile_sb: RTL and testbench

Parametrised multi-read-port general-purpose register file with an integrated per-register busy scoreboard, for the pipelined/multi-cycle NPC core. It gives the decode stage NR_RD simultaneous combinational operand reads, optional same-cycle write-to-read bypass and a hardwired zero register. Issue logic claims destination registers; writeback releases them, so decode can detect RAW hazards from the per-port busy flags.

---
 rtl/ysyx_24100005_regfile_sb_if.sv | 29 ++
 rtl/ysyx_24100005_regfile_sb.sv | 79 +++++++
 tb/tb_ysyx_24100005_regfile_sb.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24100005_regfile_sb_if.sv
// Bundle for the register-file bus: writeback, read ports, claim port and scoreboard view.
// Latency: none; wires only.
// Backpressure: none on writeback; a claim is held off only through claim_ok.
interface ysyx_24100005_regfile_sb_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NR_RD      = 2
);
  logic                        wen;
  logic [ADDR_WIDTH-1:0]       waddr;
  logic [DATA_WIDTH-1:0]       wdata;
  logic [NR_RD*ADDR_WIDTH-1:0] raddr;
  logic [NR_RD*DATA_WIDTH-1:0] rdata;
  logic [NR_RD-1:0]            rbusy;
  logic                        claim_en;
  logic [ADDR_WIDTH-1:0]       claim_addr;
  logic                        claim_ok;
  logic [2**ADDR_WIDTH-1:0]    busy_vec;

  modport master (
    output wen, waddr, wdata, raddr, claim_en, claim_addr,
    input  rdata, rbusy, claim_ok, busy_vec
  );

  modport slave (
    input  wen, waddr, wdata, raddr, claim_en, claim_addr,
    output rdata, rbusy, claim_ok, busy_vec
  );
endinterface

// File: rtl/ysyx_24100005_regfile_sb.sv
// Multi-read-port register file with a per-register busy scoreboard for RAW hazard detection.
// Latency: reads and claim_ok are combinational; writes and busy updates land on the rising edge.
// Backpressure: writeback is always accepted; a claim on a busy register is refused (claim_ok=0).
module ysyx_24100005_regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NR_RD      = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input logic                     clk,
  input logic                     rst,
  ysyx_24100005_regfile_sb_if.slave bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_nxt;
  logic                  byp_wen;
  logic                  wr_ok;
  logic                  claim_byp;
  logic                  claim_ok_c;
  logic [NR_RD*DATA_WIDTH-1:0] rdata_c;
  logic [NR_RD-1:0]            rbusy_c;

  // Bypass is suppressed while reset is held so every read port shows 0.
  assign byp_wen   = (BYPASS != 0) && bus.wen && rst;
  assign wr_ok     = bus.wen && !((ZERO_REG != 0) && (bus.waddr == '0));
  assign claim_byp = byp_wen && (bus.waddr == bus.claim_addr);
  assign claim_ok_c = bus.claim_en && (!busy[bus.claim_addr] || claim_byp);

  // Next scoreboard: release first, then a same-cycle claim re-sets the bit.
  always_comb begin
    busy_nxt = busy;
    if (bus.wen)
      busy_nxt[bus.waddr] = 1'b0;
    if (claim_ok_c)
      busy_nxt[bus.claim_addr] = 1'b1;
    if (ZERO_REG != 0)
      busy_nxt[0] = 1'b0;
  end

  // Register array and scoreboard state; reset clears both immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        rf[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_ok)
        rf[bus.waddr] <= bus.wdata;
      busy <= busy_nxt;
    end
  end

  // Per-port operand read: zero register, then same-cycle writeback, then array.
  always_comb begin
    rdata_c = '0;
    rbusy_c = '0;
    for (int i = 0; i < NR_RD; i++) begin
      if ((ZERO_REG != 0) && (bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH] == '0)) begin
        rdata_c[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        rbusy_c[i] = 1'b0;
      end else if (byp_wen && (bus.waddr == bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        rdata_c[i*DATA_WIDTH +: DATA_WIDTH] = bus.wdata;
        rbusy_c[i] = 1'b0;
      end else begin
        rdata_c[i*DATA_WIDTH +: DATA_WIDTH] = rf[bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH]];
        rbusy_c[i] = busy[bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH]];
      end
    end
  end

  assign bus.rdata    = rdata_c;
  assign bus.rbusy    = rbusy_c;
  assign bus.claim_ok = claim_ok_c;
  assign bus.busy_vec = busy;
endmodule

// File: tb/tb_ysyx_24100005_regfile_sb.sv
// Bench for the register file scoreboard: default, no-bypass and wide/no-zero-register builds.
// Latency: checks combinational outputs at the falling edge, state effects one edge later.
// Backpressure: exercises refused claims and same-cycle release/claim.
module tb_ysyx_24100005_regfile_sb;
  logic clk;
  logic rst;

  ysyx_24100005_regfile_sb_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_RD(2)) b0 ();
  ysyx_24100005_regfile_sb_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_RD(2)) b1 ();
  ysyx_24100005_regfile_sb_if #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .NR_RD(3)) b2 ();

  ysyx_24100005_regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_RD(2), .ZERO_REG(1), .BYPASS(1))
    u0 (.clk(clk), .rst(rst), .bus(b0));
  ysyx_24100005_regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_RD(2), .ZERO_REG(1), .BYPASS(0))
    u1 (.clk(clk), .rst(rst), .bus(b1));
  ysyx_24100005_regfile_sb #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .NR_RD(3), .ZERO_REG(0), .BYPASS(1))
    u2 (.clk(clk), .rst(rst), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        cen;
    logic [4:0]  caddr;
    logic [31:0] exp_rd0;
    logic [31:0] exp_rd1;
    logic [1:0]  exp_rbusy;
    logic        exp_cok;
    logic [31:0] exp_bvec;
  } vec_t;

  typedef struct {
    string       name;
    logic [63:0] val;
  } exp_t;

  exp_t sbq[$];
  vec_t vt[12];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic push_exp(input string n, input logic [63:0] v);
    exp_t e;
    e.name = n;
    e.val  = v;
    sbq.push_back(e);
  endtask

  task automatic pop_chk(input logic [63:0] act);
    exp_t e;
    n_vec++;
    if (sbq.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: got %h with nothing expected", act);
    end else begin
      e = sbq.pop_front();
      if (act !== e.val) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  endtask

  function automatic vec_t mk(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [4:0] r0, input logic [4:0] r1,
                              input logic cen, input logic [4:0] ca,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [1:0] eb, input logic ec, input logic [31:0] ev);
    vec_t v;
    v.wen = wen; v.waddr = wa; v.wdata = wd; v.ra0 = r0; v.ra1 = r1;
    v.cen = cen; v.caddr = ca; v.exp_rd0 = e0; v.exp_rd1 = e1;
    v.exp_rbusy = eb; v.exp_cok = ec; v.exp_bvec = ev;
    return v;
  endfunction

  task automatic idle_all();
    b0.wen = 0; b0.waddr = 0; b0.wdata = 0; b0.raddr = 0; b0.claim_en = 0; b0.claim_addr = 0;
    b1.wen = 0; b1.waddr = 0; b1.wdata = 0; b1.raddr = 0; b1.claim_en = 0; b1.claim_addr = 0;
    b2.wen = 0; b2.waddr = 0; b2.wdata = 0; b2.raddr = 0; b2.claim_en = 0; b2.claim_addr = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    idle_all();
    b0.raddr = {5'd9, 5'd5};
    b0.claim_en = 1; b0.claim_addr = 5'd9;
    #2;
    // Reset state
    push_exp("rst_rd0", 0); push_exp("rst_rbusy", 0);
    push_exp("rst_bvec", 0); push_exp("rst_cok", 1);
    pop_chk(b0.rdata[31:0]); pop_chk(b0.rbusy);
    pop_chk(b0.busy_vec); pop_chk(b0.claim_ok);
    b0.claim_en = 0;
    #10 rst = 1'b1;

    // Default build: bypass on, zero register on
    vt[0]  = mk(1, 3, 32'h12345678, 3, 0, 0, 0, 32'h12345678, 0,            2'b00, 0, 0);
    vt[1]  = mk(0, 0, 0,            3, 3, 0, 0, 32'h12345678, 32'h12345678, 2'b00, 0, 0);
    vt[2]  = mk(1, 0, 32'hFFFFFFFF, 0, 3, 0, 0, 0,            32'h12345678, 2'b00, 0, 0);
    vt[3]  = mk(0, 0, 0,            0, 3, 1, 9, 0,            32'h12345678, 2'b00, 1, 0);
    vt[4]  = mk(0, 0, 0,            9, 9, 1, 9, 0,            0,            2'b11, 0, 32'h200);
    vt[5]  = mk(1, 9, 32'h99,       9, 3, 0, 0, 32'h99,       32'h12345678, 2'b00, 0, 32'h200);
    vt[6]  = mk(0, 0, 0,            2, 9, 1, 4, 0,            32'h99,       2'b00, 1, 0);
    vt[7]  = mk(1, 4, 32'h44444444, 4, 4, 1, 4, 32'h44444444, 32'h44444444, 2'b00, 1, 32'h10);
    vt[8]  = mk(0, 0, 0,            4, 7, 0, 0, 32'h44444444, 0,            2'b01, 0, 32'h10);
    vt[9]  = mk(1, 7, 32'hA5A5A5A5, 7, 4, 0, 0, 32'hA5A5A5A5, 32'h44444444, 2'b10, 0, 32'h10);
    vt[10] = mk(0, 0, 0,            7, 0, 1, 0, 32'hA5A5A5A5, 0,            2'b00, 1, 32'h10);
    vt[11] = mk(0, 0, 0,            0, 0, 1, 0, 0,            0,            2'b00, 1, 32'h10);

    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      b0.wen = vt[i].wen; b0.waddr = vt[i].waddr; b0.wdata = vt[i].wdata;
      b0.raddr = {vt[i].ra1, vt[i].ra0};
      b0.claim_en = vt[i].cen; b0.claim_addr = vt[i].caddr;
      push_exp($sformatf("v%0d_rd0", i), vt[i].exp_rd0);
      push_exp($sformatf("v%0d_rd1", i), vt[i].exp_rd1);
      push_exp($sformatf("v%0d_rbusy", i), vt[i].exp_rbusy);
      push_exp($sformatf("v%0d_cok", i), vt[i].exp_cok);
      push_exp($sformatf("v%0d_bvec", i), vt[i].exp_bvec);
      @(negedge clk);
      pop_chk(b0.rdata[31:0]); pop_chk(b0.rdata[63:32]);
      pop_chk(b0.rbusy); pop_chk(b0.claim_ok); pop_chk(b0.busy_vec);
    end
    @(posedge clk); #1;
    b0.wen = 0; b0.claim_en = 0;

    // No-bypass build: old data on same-cycle write, claim refused on busy release
    b1.wen = 1; b1.waddr = 7; b1.wdata = 32'h11111111;
    @(posedge clk); #1;
    b1.wdata = 32'hA5A5A5A5; b1.raddr = {5'd0, 5'd7};
    push_exp("nb_rd_old", 32'h11111111); push_exp("nb_rbusy", 0);
    @(negedge clk); pop_chk(b1.rdata[31:0]); pop_chk(b1.rbusy);
    @(posedge clk); #1;
    b1.wen = 0; b1.claim_en = 1; b1.claim_addr = 4;
    push_exp("nb_rd_new", 32'hA5A5A5A5); push_exp("nb_cok_free", 1);
    @(negedge clk); pop_chk(b1.rdata[31:0]); pop_chk(b1.claim_ok);
    @(posedge clk); #1;
    b1.wen = 1; b1.waddr = 4; b1.wdata = 32'h44;
    push_exp("nb_cok_busy", 0); push_exp("nb_bvec_pre", 32'h10);
    @(negedge clk); pop_chk(b1.claim_ok); pop_chk(b1.busy_vec);
    @(posedge clk); #1;
    b1.wen = 0; b1.claim_en = 0; b1.raddr = {5'd0, 5'd4};
    push_exp("nb_bvec_post", 0); push_exp("nb_rd4", 32'h44); push_exp("nb_rbusy4", 0);
    @(negedge clk); pop_chk(b1.busy_vec); pop_chk(b1.rdata[31:0]); pop_chk(b1.rbusy);

    // Wide build: writable x0, claimable x0, three independent ports
    @(posedge clk); #1;
    b2.wen = 1; b2.waddr = 0; b2.wdata = 64'h1;
    push_exp("w_x0_byp", 64'h1);
    @(negedge clk); pop_chk(b2.rdata[63:0]);
    @(posedge clk); #1;
    b2.wen = 0; b2.claim_en = 1; b2.claim_addr = 0;
    push_exp("w_x0_rd", 64'h1); push_exp("w_cok0", 1);
    @(negedge clk); pop_chk(b2.rdata[63:0]); pop_chk(b2.claim_ok);
    @(posedge clk); #1;
    b2.claim_en = 0; b2.wen = 1; b2.waddr = 5; b2.wdata = 64'hCAFE000000000005;
    push_exp("w_bvec0", 64'h1);
    @(negedge clk); pop_chk(b2.busy_vec);
    @(posedge clk); #1;
    b2.waddr = 10; b2.wdata = 64'h123456789ABCDEF0;
    @(posedge clk); #1;
    b2.wen = 0; b2.raddr = {4'd10, 4'd5, 4'd0};
    push_exp("w_p0", 64'h1); push_exp("w_p1", 64'hCAFE000000000005);
    push_exp("w_p2", 64'h123456789ABCDEF0); push_exp("w_rbusy", 3'b001);
    @(negedge clk);
    pop_chk(b2.rdata[63:0]); pop_chk(b2.rdata[127:64]);
    pop_chk(b2.rdata[191:128]); pop_chk(b2.rbusy);

    // Mid-operation reset on the default build
    @(posedge clk); #1;
    b0.wen = 1; b0.waddr = 5; b0.wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    b0.wen = 0; b0.raddr = {5'd4, 5'd5};
    push_exp("pre_rst_rd", 32'hDEADBEEF); push_exp("pre_rst_bvec", 32'h10);
    @(negedge clk); pop_chk(b0.rdata[31:0]); pop_chk(b0.busy_vec);
    #1;
    b0.wen = 1; b0.waddr = 5; b0.wdata = 32'h55555555;
    b0.claim_en = 1; b0.claim_addr = 4;
    rst = 1'b0;
    #1;
    push_exp("rst_mid_rd", 0); push_exp("rst_mid_bvec", 0);
    push_exp("rst_mid_cok", 1); push_exp("rst_mid_rbusy", 0);
    pop_chk(b0.rdata[31:0]); pop_chk(b0.busy_vec);
    pop_chk(b0.claim_ok); pop_chk(b0.rbusy);
    b0.wen = 0; b0.claim_en = 0;
    #1 rst = 1'b1;
    @(negedge clk);
    push_exp("post_rst_rd", 0); push_exp("post_rst_bvec", 0);
    pop_chk(b0.rdata[31:0]); pop_chk(b0.busy_vec);

    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
